// File: rtl/valu_arbiter_if.sv
// Request, vector-ALU and response signals of the shared vector ALU arbiter.
// slave: arbiter side; master: requesters, vector ALU and response consumer.
interface valu_arbiter_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned TAG_W  = 4
);
    localparam int unsigned VW = LANES * LANE_W;

    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic             req0_csub;
    logic [1:0]       req0_bcast;
    logic [VW-1:0]    req0_a;
    logic [VW-1:0]    req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic             req1_csub;
    logic [1:0]       req1_bcast;
    logic [VW-1:0]    req1_a;
    logic [VW-1:0]    req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic [2:0]       valu_op;
    logic             valu_csub;
    logic [VW-1:0]    valu_a;
    logic [VW-1:0]    valu_b;
    logic [VW-1:0]    valu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [VW-1:0]    rsp_result;

    modport slave (
        input  req0_valid, req0_op, req0_csub, req0_bcast, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_csub, req1_bcast, req1_a, req1_b, req1_tag,
        output req1_ready,
        output valu_op, valu_csub, valu_a, valu_b,
        input  valu_result,
        output rsp_valid, rsp_id, rsp_tag, rsp_result,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_csub, req0_bcast, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_csub, req1_bcast, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  valu_op, valu_csub, valu_a, valu_b,
        output valu_result,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result,
        output rsp_ready
    );
endinterface

// File: rtl/valu_arbiter.sv
// Round-robin two-requester arbiter with issue slot (S1) and response slot (S2) for the vector ALU.
// Optional performance counters when VALU_ARB_PERF_EN is defined.
module valu_arbiter #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    valu_arbiter_if.slave  bus
`ifdef VALU_ARB_PERF_EN
    ,
    output logic [15:0]    perf_grant0,
    output logic [15:0]    perf_grant1,
    output logic [15:0]    perf_stall
`endif
);
    localparam int unsigned VW = LANES * LANE_W;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic             s1_csub;
    logic [VW-1:0]    s1_a;
    logic [VW-1:0]    s1_b;
    logic             s1_id;
    logic [TAG_W-1:0] s1_tag;
    logic             last;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [VW-1:0]    rsp_result_q;

    logic             s2_load;
    logic             s1_free;
    logic             cand0;
    logic             cand1;
    logic             hs0;
    logic             hs1;

    logic [2:0]       sel_op;
    logic             sel_csub;
    logic [VW-1:0]    sel_a;
    logic [VW-1:0]    sel_b;
    logic [TAG_W-1:0] sel_tag;

    function automatic logic [VW-1:0] bcast_expand(input logic [VW-1:0] v, input logic en);
        return en ? {LANES{v[LANE_W-1:0]}} : v;
    endfunction

    // Advance rules, candidate selection and ready generation.
    always_comb begin
        s2_load = s1_valid && (!rsp_valid_q || bus.rsp_ready);
        s1_free = !s1_valid || s2_load;
        cand0   = bus.req0_valid && (!bus.req1_valid || last);
        cand1   = bus.req1_valid && (!bus.req0_valid || !last);
        hs0     = rst_n && cand0 && s1_free;
        hs1     = rst_n && cand1 && s1_free;
    end

    assign bus.req0_ready = hs0;
    assign bus.req1_ready = hs1;

    // Operand mux; broadcast expansion happens before the issue slot.
    always_comb begin
        sel_op   = bus.req0_op;
        sel_csub = bus.req0_csub;
        sel_a    = bcast_expand(bus.req0_a, bus.req0_bcast[0]);
        sel_b    = bcast_expand(bus.req0_b, bus.req0_bcast[1]);
        sel_tag  = bus.req0_tag;
        if (hs1) begin
            sel_op   = bus.req1_op;
            sel_csub = bus.req1_csub;
            sel_a    = bcast_expand(bus.req1_a, bus.req1_bcast[0]);
            sel_b    = bcast_expand(bus.req1_b, bus.req1_bcast[1]);
            sel_tag  = bus.req1_tag;
        end
    end

    // S1 issue slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'd0;
            s1_csub  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= 1'b0;
            s1_tag   <= '0;
            last     <= 1'b1;
        end else if (hs0 || hs1) begin
            s1_valid <= 1'b1;
            s1_op    <= sel_op;
            s1_csub  <= sel_csub;
            s1_a     <= sel_a;
            s1_b     <= sel_b;
            s1_id    <= hs1;
            s1_tag   <= sel_tag;
            last     <= hs1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 response slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
        end else if (s2_load) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= s1_id;
            rsp_tag_q    <= s1_tag;
            rsp_result_q <= bus.valu_result;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.valu_op    = s1_op;
    assign bus.valu_csub  = s1_csub;
    assign bus.valu_a     = s1_a;
    assign bus.valu_b     = s1_b;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;

`ifdef VALU_ARB_PERF_EN
    logic [15:0] perf_g0_q;
    logic [15:0] perf_g1_q;
    logic [15:0] perf_stall_q;
    logic        stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign stall = (bus.req0_valid || bus.req1_valid) && !(hs0 || hs1);

    // Saturating handshake and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_g0_q    <= 16'd0;
            perf_g1_q    <= 16'd0;
            perf_stall_q <= 16'd0;
        end else begin
            if (hs0)   perf_g0_q    <= sat_inc(perf_g0_q);
            if (hs1)   perf_g1_q    <= sat_inc(perf_g1_q);
            if (stall) perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_grant0 = perf_g0_q;
    assign perf_grant1 = perf_g1_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule
